pipeline_hazard_ctrl: RTL

- Central stall/flush controller for the 5-stage pipeline.
- Drives IF/ID write-enable and synchronous flush, PC write-enable, and the ID/EX bubble/hold controls.
- Resolves three hazard classes:
  - load-use data hazards;
  - taken branches resolved in EX;
  - multi-cycle multiply/divide ops occupying EX, with watchdog timeout.

---
 rtl/hazard_pkg.sv | 12 +
 rtl/hazard_lu_detect.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

   localparam int DEF_REG_ADDR_W = 5;
   localparam logic [DEF_REG_ADDR_W-1:0] X0 = '0;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/hazard_lu_detect.sv
// rtl/hazard_lu_detect.sv - load-use comparator: a load in EX feeds a source read by ID
module hazard_lu_detect
   import hazard_pkg::*;
#(
   parameter int ADDR_W = DEF_REG_ADDR_W
) (
   input  logic              ex_mem_read,
   input  logic [ADDR_W-1:0] ex_rd,
   input  logic [ADDR_W-1:0] id_rs1,
   input  logic [ADDR_W-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   output logic              lu
);

   logic rd_live;
   logic hit_rs1;
   logic hit_rs2;

   // x0 is hardwired to zero, so a load targeting it never creates a dependency
   assign rd_live = (ex_rd != ADDR_W'(X0));
   assign hit_rs1 = id_use_rs1 && (id_rs1 == ex_rd);
   assign hit_rs2 = id_use_rs2 && (id_rs2 == ex_rd);
   assign lu      = ex_mem_read && rd_live && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for the 5-stage pipeline
// Optional stall/flush counters enabled by HAZARD_STALL_CNT_EN.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  branch_taken,
   input  logic                  md_start,
   input  logic                  md_done,
   output logic                  pc_we,
   output logic                  we_IF_ID,
   output logic                  rst_IF_ID,
   output logic                  we_ID_EX,
   output logic                  flush_ID_EX,
`ifdef HAZARD_STALL_CNT_EN
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_count,
`endif
   output logic                  md_timeout
);

   localparam int MD_CNT_W = $clog2(MD_TIMEOUT);
   localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_TIMEOUT - 1);

   state_t              state, state_d;
   logic [MD_CNT_W-1:0] md_cnt, md_cnt_d;
   logic                lu;

   hazard_lu_detect #(
      .ADDR_W (REG_ADDR_W)
   ) u_lu_detect (
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .lu          (lu)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         state  <= state_d;
         md_cnt <= md_cnt_d;
      end
   end

   always_comb begin
      state_d     = state;
      md_cnt_d    = md_cnt;
      pc_we       = 1'b1;
      we_IF_ID    = 1'b1;
      we_ID_EX    = 1'b1;
      rst_IF_ID   = 1'b0;
      flush_ID_EX = 1'b0;
      md_timeout  = 1'b0;
      if (rst) begin
         pc_we       = 1'b0;
         we_IF_ID    = 1'b0;
         we_ID_EX    = 1'b0;
         rst_IF_ID   = 1'b1;
         flush_ID_EX = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (branch_taken) begin
                  rst_IF_ID   = 1'b1;
                  flush_ID_EX = 1'b1;
               end else if (md_start && !md_done) begin
                  pc_we    = 1'b0;
                  we_IF_ID = 1'b0;
                  we_ID_EX = 1'b0;
                  state_d  = MD_BUSY;
                  md_cnt_d = MD_CNT_W'(1);
               end else if (md_start) begin
                  state_d = RUN;
               end else if (lu) begin
                  // one bubble suffices: the load leaves EX and a NOP takes its place
                  pc_we       = 1'b0;
                  we_IF_ID    = 1'b0;
                  flush_ID_EX = 1'b1;
               end
            end
            MD_BUSY: begin
               if (md_done) begin
                  state_d  = RUN;
                  md_cnt_d = '0;
               end else if (md_cnt == MD_LAST) begin
                  md_timeout = 1'b1;
                  state_d    = RUN;
                  md_cnt_d   = '0;
               end else begin
                  pc_we    = 1'b0;
                  we_IF_ID = 1'b0;
                  we_ID_EX = 1'b0;
                  md_cnt_d = md_cnt + MD_CNT_W'(1);
               end
            end
            default: begin
               state_d  = RUN;
               md_cnt_d = '0;
            end
         endcase
      end
   end

`ifdef HAZARD_STALL_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (!pc_we && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (rst_IF_ID && (flush_count != '1))
            flush_count <= flush_count + CNT_W'(1);
      end
   end
`endif

endmodule
